ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, meaning the RAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning the RAM data bus width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports reqN_valid, input, 1, requester N (N=0,1) has a pending command.
REQ-006 SHALL have ports reqN_ready, output, 1, command accepted this cycle (valid & ready = handshake).
REQ-007 SHALL have ports reqN_we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have ports reqN_addr, input, ADDR_WIDTH, word address.
REQ-009 SHALL have ports reqN_wdata, input, DATA_WIDTH, write data.
REQ-010 SHALL have ports rspN_valid, output, 1, one-cycle pulse: read data for requester N.
REQ-011 SHALL have ports rspN_rdata, output, DATA_WIDTH, read data, valid only with rspN_valid.
REQ-012 SHALL have ports ram_addr (output, ADDR_WIDTH), ram_cs, ram_we, ram_oe (output, 1 each) driving the RAM.
REQ-013 SHALL have port ram_data, inout, DATA_WIDTH, shared tri-state RAM data bus.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WR, RD1, RD2.
REQ-016 In IDLE with any reqN_valid, SHALL grant one requester, assert only its reqN_ready combinationally that cycle, latch addr/we/wdata and owner, and go to WR (we=1) or RD1 (we=0).
REQ-017 SHALL never assert reqN_ready outside IDLE nor both readies in one cycle.
REQ-018 Arbitration SHALL be round-robin: on both valid, grant the requester not granted last; on one valid, grant it regardless of history.
REQ-019 Last-grant register SHALL update only on a handshake.
REQ-020 WR (1 cycle): ram_cs=1, ram_we=1, ram_oe=0, ram_data driven with latched wdata; next state IDLE.
REQ-021 RD1: ram_cs=1, ram_we=0, ram_oe=1, ram_data released (high-Z); next state RD2.
REQ-022 RD2: same strobes as RD1; ram_data sampled into rdata register at end of cycle; next state IDLE.
REQ-023 rspN_valid SHALL pulse for exactly one cycle, the cycle after RD2, for the owning requester only; rspN_rdata holds the value until the next read completes.
REQ-024 Latency: write handshake at edge T -> RAM write at T+1; read handshake at edge T -> rspN_valid high in cycle T+3.
REQ-025 Throughput: one write per 2 cycles, one read per 3 cycles; a new handshake may occur in the same cycle as rspN_valid.
REQ-026 ram_addr, ram_cs, ram_we, ram_oe SHALL be registered outputs; in IDLE ram_cs=ram_we=ram_oe=0 and ram_addr holds its last value.
REQ-027 ram_data SHALL be driven only in WR; all other states high-Z (no bus contention with RAM read drive).
REQ-028 Requester inputs changing while not ready SHALL have no effect.

Reset
REQ-029 rst asserted SHALL immediately force state IDLE, ram_cs/ram_we/ram_oe=0, ram_addr=0, ram_data high-Z, all ready/rsp_valid=0, rdata=0, busy=0.
REQ-030 Last-grant SHALL reset to requester 1 so requester 0 wins the first contention.
REQ-031 A transaction in flight at reset SHALL be dropped with no response; no RAM write SHALL complete after rst rises.

Structure
REQ-032 Package ram_ctrl_pkg SHALL hold the FSM state enum and default ADDR_WIDTH/DATA_WIDTH constants.
REQ-033 Round-robin grant logic SHALL be a sub-module rr_arbiter2 (2 requests in, one-hot grant out, last-grant state).

Verification
REQ-034 Write 0x1234 to addr 5 via req0, then read addr 5 via req1 -> rsp1_valid 3 cycles after read handshake, rsp1_rdata=0x1234, rsp0_valid stays 0.
REQ-035 Both valid continuously with reads -> grants alternate 0,1,0,1; first grant after reset is 0.
REQ-036 Only req1 valid for 3 commands -> req1 granted each time, no idle gaps beyond FSM minimum.
REQ-037 Write to addr 0x3FFFFFFF (top bit set) and addr 0 -> both read back distinct values (0xBEEF, 0x0001).
REQ-038 rst asserted during WR -> outputs zero/high-Z same cycle, target word unchanged, no rsp pulse.
REQ-039 Check every cycle: ram_data driven by controller only when ram_we=1; never X on bus during RD2 sample.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
//   Shared definitions for the two-requester RAM arbiter/controller.
//   Contents:
//     RAM_ADDR_WIDTH / RAM_DATA_WIDTH : default RAM word address and data widths
//     state_t                         : controller FSM states (IDLE, WR, RD1, RD2)
`timescale 1ns/1ps
package ram_ctrl_pkg;

  localparam int RAM_ADDR_WIDTH = 30;
  localparam int RAM_DATA_WIDTH = 16;

  // IDLE accepts a command; WR is the single write strobe cycle;
  // RD1/RD2 hold the read strobes for two cycles so the RAM has a full
  // cycle of output enable before the data is captured.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD1  = 2'd2,
    RD2  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin arbiter with a one-hot combinational grant.
//   Ports:
//     clk, rst : clock and asynchronous active-high reset
//     req      : request vector, bit N = requester N wants the resource
//     advance  : a grant was actually accepted this cycle (handshake)
//     grant    : one-hot grant, all-zero when nothing is requested
`timescale 1ns/1ps
module rr_arbiter2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 means requester 1 was granted last. It starts at 1 so requester 0
  // wins the very first contention after reset.
  logic last_grant;

  // On contention hand the resource to whoever was not served last; with a
  // single request the history is ignored and that requester simply wins.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // History only moves when a grant is really taken, so a grant offered
  // while the controller is busy never disturbs fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one asynchronous tri-state RAM between two requesters using
//   round-robin arbitration. One command is in flight at a time.
//   Ports:
//     clk, rst                 : clock, asynchronous active-high reset
//     reqN_valid/ready         : command handshake for requester N (N=0,1)
//     reqN_we/addr/wdata       : command fields, 1=write 0=read
//     rspN_valid/rdata         : one-cycle read response pulse and held data
//     ram_addr/cs/we/oe        : registered RAM control outputs
//     ram_data                 : shared bidirectional RAM data bus
//     busy                     : high whenever a command is being executed
`timescale 1ns/1ps
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  busy
);

  state_t                state;
  logic                  owner;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rsp_valid_q;
  logic [1:0]            grant;
  logic                  idle;
  logic                  handshake;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign idle = (state == IDLE);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (handshake),
    .grant   (grant)
  );

  // Readies are only offered while idle; the reset term keeps them low for
  // the whole time reset is held, not just after the state register clears.
  assign req0_ready = idle & grant[0] & ~rst;
  assign req1_ready = idle & grant[1] & ~rst;
  assign handshake  = req0_ready | req1_ready;

  // Command fields of whichever requester holds the grant this cycle.
  assign sel_we    = grant[1] ? req1_we    : req0_we;
  assign sel_addr  = grant[1] ? req1_addr  : req0_addr;
  assign sel_wdata = grant[1] ? req1_wdata : req0_wdata;

  // The controller drives the bus only during the write strobe cycle, so it
  // can never fight the RAM while output enable is high.
  assign ram_data = (state == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign busy       = ~idle;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rdata_q;
  assign rsp1_rdata = rdata_q;

  // Controller FSM. The RAM strobes are computed one state ahead so they
  // come straight from flops and line up with the state they belong to.
  // Reset drops any command in flight: the write strobe falls immediately
  // and no response is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 2'b00;
      ram_addr    <= '0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (handshake) begin
            owner    <= grant[1];
            ram_addr <= sel_addr;
            wdata_q  <= sel_wdata;
            ram_cs   <= 1'b1;
            if (sel_we) begin
              state  <= WR;
              ram_we <= 1'b1;
              ram_oe <= 1'b0;
            end else begin
              state  <= RD1;
              ram_we <= 1'b0;
              ram_oe <= 1'b1;
            end
          end
        end
        WR: begin
          state  <= IDLE;
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          ram_oe <= 1'b0;
        end
        RD1: begin
          state <= RD2;
        end
        RD2: begin
          rdata_q     <= ram_data;
          rsp_valid_q <= owner ? 2'b10 : 2'b01;
          state       <= IDLE;
          ram_cs      <= 1'b0;
          ram_we      <= 1'b0;
          ram_oe      <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          ram_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Self-checking bench for ram_arbiter: a behavioural tri-state RAM sits on
//   the bus, directed scenarios cover the documented corner cases, and a
//   randomized phase is compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int AW = 30;
  localparam int DW = 16;
  localparam logic [AW-1:0] TOP_ADDR = 30'h3FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic          req0_we = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_cs, ram_we, ram_oe;
  wire  [DW-1:0] ram_data;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .ram_addr   (ram_addr),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_oe     (ram_oe),
    .ram_data   (ram_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Behavioural RAM: a small array indexed by the top address bit plus the
  // low three bits, enough to keep every address the bench uses distinct.
  logic [DW-1:0] ram_mem [16];

  function automatic int ram_idx(input logic [AW-1:0] a);
    return int'({a[AW-1], a[2:0]});
  endfunction

  function automatic logic [DW-1:0] preload(input int i);
    return 16'hC000 | 16'(i * 17);
  endfunction

  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_mem[ram_idx(ram_addr)] : {DW{1'bz}};

  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_idx(ram_addr)] <= ram_data;
  end

  // Reference memory keyed by the full address.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return preload(ram_idx(a));
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = int'($urandom_range(8));
    return (r == 8) ? TOP_ADDR : AW'(r);
  endfunction

  // Per-cycle bus and handshake protocol monitor.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if (req0_ready && req1_ready) begin
        failures++;
        $display("[TB] FAIL both_ready: cycle %0d got both readies high, expected at most one", cyc);
      end
      checks++;
      if (busy && (req0_ready || req1_ready)) begin
        failures++;
        $display("[TB] FAIL ready_while_busy: cycle %0d got ready with busy=1, expected no ready", cyc);
      end
      if (ram_we) begin
        checks++;
        if (!(ram_cs && !ram_oe)) begin
          failures++;
          $display("[TB] FAIL write_strobes: cycle %0d got cs=%0b oe=%0b, expected cs=1 oe=0", cyc, ram_cs, ram_oe);
        end
      end
      if (ram_cs && ram_oe) begin
        checks++;
        if (ram_data !== ram_mem[ram_idx(ram_addr)]) begin
          failures++;
          $display("[TB] FAIL bus_read: cycle %0d got bus %0h, expected RAM value %0h", cyc, ram_data, ram_mem[ram_idx(ram_addr)]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic reset_dut();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents one command from requester n and holds it until handshake.
  // Entered and left at 1ns after a rising edge; hs is the handshake cycle.
  task automatic apply_stimulus(input int n, input bit we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, output int hs);
    bit ok;
    if (n == 0) begin
      req0_we = we; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
    end else begin
      req1_we = we; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
    end
    ok = 1'b0;
    hs = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) begin
        hs = cyc;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL handshake_timeout: requester %0d got no ready in 20 cycles, expected a grant", n);
    end
  endtask

  // Watches ncyc cycles of responses, recording the first pulse for n.
  task automatic observe_rsp(input int n, input int ncyc, output int first_c,
                             output logic [DW-1:0] d, output int cnt, output int other);
    first_c = -1; d = '0; cnt = 0; other = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if ((n == 0) ? rsp0_valid : rsp1_valid) begin
        if (cnt == 0) begin
          first_c = cyc;
          d = (n == 0) ? rsp0_rdata : rsp1_rdata;
        end
        cnt++;
      end
      if ((n == 0) ? rsp1_valid : rsp0_valid) other++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [AW+DW*2+7:0] got;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    got = {ram_addr, ram_cs, ram_we, ram_oe, busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %0h, expected all zero", got);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    int hs_w, hs_r, rc, cnt, other;
    logic [DW-1:0] d;
    apply_stimulus(0, 1'b1, 30'd5, 16'h1234, hs_w);
    @(negedge clk);
    checks++;
    if ({ram_cs, ram_we, ram_oe} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL wr_strobes: got cs/we/oe=%03b, expected 110", {ram_cs, ram_we, ram_oe});
    end
    checks++;
    if (ram_addr !== 30'd5) begin
      failures++;
      $display("[TB] FAIL wr_addr: got %0h, expected 5", ram_addr);
    end
    checks++;
    if (ram_data !== 16'h1234) begin
      failures++;
      $display("[TB] FAIL wr_data: got %0h, expected 1234", ram_data);
    end
    @(posedge clk);
    #1;
    apply_stimulus(1, 1'b0, 30'd5, 16'h0000, hs_r);
    checks++;
    if (hs_r != hs_w + 2) begin
      failures++;
      $display("[TB] FAIL write_throughput: read handshake at %0d, expected %0d", hs_r, hs_w + 2);
    end
    observe_rsp(1, 5, rc, d, cnt, other);
    checks++;
    if (cnt != 1 || rc != hs_r + 3) begin
      failures++;
      $display("[TB] FAIL read_latency: got %0d pulses first at %0d, expected 1 at %0d", cnt, rc, hs_r + 3);
    end
    checks++;
    if (d !== 16'h1234) begin
      failures++;
      $display("[TB] FAIL read_data: got %0h, expected 1234", d);
    end
    checks++;
    if (other != 0) begin
      failures++;
      $display("[TB] FAIL rsp0_quiet: got %0d rsp0 pulses, expected 0", other);
    end
  endtask

  task automatic test_round_robin();
    int grants, prev;
    int g;
    reset_dut();
    req0_we = 1'b0; req0_addr = 30'd1;
    req1_we = 1'b0; req1_addr = 30'd2;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    grants = 0;
    prev = -1;
    for (int i = 0; i < 40 && grants < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        g = req1_ready ? 1 : 0;
        checks++;
        if (g != grants % 2) begin
          failures++;
          $display("[TB] FAIL rr_order: grant #%0d went to %0d, expected %0d", grants, g, grants % 2);
        end
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != 3) begin
            failures++;
            $display("[TB] FAIL rr_spacing: gap %0d cycles, expected 3", cyc - prev);
          end
        end
        prev = cyc;
        grants++;
      end
    end
    checks++;
    if (grants != 4) begin
      failures++;
      $display("[TB] FAIL rr_timeout: got %0d grants, expected 4", grants);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single_requester();
    int grants, prev;
    req1_we = 1'b0;
    req1_addr = 30'd3;
    req1_valid = 1'b1;
    grants = 0;
    prev = -1;
    for (int i = 0; i < 30 && grants < 3; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        checks++;
        if (!req1_ready) begin
          failures++;
          $display("[TB] FAIL single_grant: grant #%0d went to 0, expected 1", grants);
        end
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != 3) begin
            failures++;
            $display("[TB] FAIL single_spacing: gap %0d cycles, expected 3", cyc - prev);
          end
        end
        prev = cyc;
        grants++;
      end
    end
    checks++;
    if (grants != 3) begin
      failures++;
      $display("[TB] FAIL single_timeout: got %0d grants, expected 3", grants);
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_boundary();
    int hs, rc, cnt, other;
    logic [DW-1:0] d;
    apply_stimulus(0, 1'b1, TOP_ADDR, 16'hBEEF, hs);
    apply_stimulus(1, 1'b1, 30'd0, 16'h0001, hs);
    apply_stimulus(0, 1'b0, TOP_ADDR, 16'h0000, hs);
    observe_rsp(0, 5, rc, d, cnt, other);
    checks++;
    if (cnt != 1 || d !== 16'hBEEF) begin
      failures++;
      $display("[TB] FAIL top_addr_read: got %0d pulses data %0h, expected 1 pulse data beef", cnt, d);
    end
    apply_stimulus(0, 1'b0, 30'd0, 16'h0000, hs);
    observe_rsp(0, 5, rc, d, cnt, other);
    checks++;
    if (cnt != 1 || d !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL zero_addr_read: got %0d pulses data %0h, expected 1 pulse data 0001", cnt, d);
    end
  endtask

  task automatic test_reset_during_write();
    int hs, rc, cnt, other;
    logic [DW-1:0] d;
    logic [AW+7:0] got;
    apply_stimulus(0, 1'b1, 30'd7, 16'h5555, hs);
    apply_stimulus(1, 1'b1, 30'd7, 16'hAAAA, hs);
    req0_we = 1'b0;
    req0_addr = 30'd2;
    req0_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    got = {ram_addr, ram_cs, ram_we, ram_oe, busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("[TB] FAIL reset_in_write: got %0h, expected all zero", got);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    apply_stimulus(0, 1'b0, 30'd6, 16'h0000, hs);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    observe_rsp(0, 5, rc, d, cnt, other);
    checks++;
    if (cnt + other != 0) begin
      failures++;
      $display("[TB] FAIL dropped_read: got %0d response pulses, expected 0", cnt + other);
    end
    apply_stimulus(0, 1'b0, 30'd7, 16'h0000, hs);
    observe_rsp(0, 5, rc, d, cnt, other);
    checks++;
    if (cnt != 1 || d !== 16'h5555) begin
      failures++;
      $display("[TB] FAIL aborted_write: got %0d pulses data %0h, expected 1 pulse data 5555", cnt, d);
    end
  endtask

  typedef struct {
    int            c;
    int            n;
    logic [DW-1:0] d;
  } rsp_t;

  task automatic test_random();
    bit            pend [2];
    bit            cwe [2];
    logic [AW-1:0] caddr [2];
    logic [DW-1:0] cdata [2];
    rsp_t          q [$];
    int            last, next_free, g, wr_cyc;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    bit            exp0, exp1, idle;
    logic [DW-1:0] got_d;

    for (int i = 0; i < 16; i++) ram_mem[i] = preload(i);
    ref_mem.delete();
    reset_dut();
    last = 1;
    next_free = cyc;
    wr_cyc = -1;
    wr_addr = '0;
    wr_data = '0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    for (int t = 0; t < 410; t++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n]) begin
          if (t < 400 && $urandom_range(2) != 0) begin
            pend[n] = 1'b1;
            cwe[n] = 1'($urandom_range(1));
            caddr[n] = pick_addr();
            cdata[n] = DW'($urandom);
          end
        end else if ($urandom_range(3) == 0) begin
          cwe[n] = 1'($urandom_range(1));
          caddr[n] = pick_addr();
          cdata[n] = DW'($urandom);
        end
      end
      req0_valid = pend[0]; req0_we = cwe[0]; req0_addr = caddr[0]; req0_wdata = cdata[0];
      req1_valid = pend[1]; req1_we = cwe[1]; req1_addr = caddr[1]; req1_wdata = cdata[1];

      @(negedge clk);
      idle = (cyc >= next_free);
      g = -1;
      if (idle && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) g = 1 - last;
        else g = pend[0] ? 0 : 1;
      end
      checks++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        failures++;
        $display("[TB] FAIL rand_ready: cycle %0d got ready=%0b%0b, expected grant %0d", cyc, req1_ready, req0_ready, g);
      end

      exp0 = (q.size() > 0) && (q[0].c == cyc) && (q[0].n == 0);
      exp1 = (q.size() > 0) && (q[0].c == cyc) && (q[0].n == 1);
      checks++;
      if (rsp0_valid !== exp0 || rsp1_valid !== exp1) begin
        failures++;
        $display("[TB] FAIL rand_rsp_valid: cycle %0d got %0b%0b, expected %0b%0b", cyc, rsp1_valid, rsp0_valid, exp1, exp0);
      end
      if (exp0 || exp1) begin
        got_d = exp1 ? rsp1_rdata : rsp0_rdata;
        checks++;
        if (got_d !== q[0].d) begin
          failures++;
          $display("[TB] FAIL rand_rdata: cycle %0d got %0h, expected %0h", cyc, got_d, q[0].d);
        end
        void'(q.pop_front());
      end

      checks++;
      if (ram_we !== (cyc == wr_cyc)) begin
        failures++;
        $display("[TB] FAIL rand_ram_we: cycle %0d got %0b, expected %0b", cyc, ram_we, cyc == wr_cyc);
      end
      if (cyc == wr_cyc) begin
        checks++;
        if (ram_addr !== wr_addr || ram_data !== wr_data) begin
          failures++;
          $display("[TB] FAIL rand_write: got addr %0h data %0h, expected addr %0h data %0h", ram_addr, ram_data, wr_addr, wr_data);
        end
      end

      if (g >= 0) begin
        last = g;
        if (cwe[g]) begin
          next_free = cyc + 2;
          wr_cyc = cyc + 1;
          wr_addr = caddr[g];
          wr_data = cdata[g];
          ref_mem[caddr[g]] = cdata[g];
        end else begin
          next_free = cyc + 3;
          q.push_back('{c: cyc + 3, n: g, d: ref_read(caddr[g])});
        end
        pend[g] = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rand_drain: got %0d outstanding reads, expected 0", q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram_mem[i] = preload(i);
    $display("[TB] starting ram_arbiter bench");
    test_reset();
    mon_en = 1'b1;
    test_write_read();
    test_round_robin();
    test_single_requester();
    test_boundary();
    test_reset_during_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
